dev_ram_responder: RTL and testbench
====================================

Name: dev_ram_responder

Overview:
- Responder (server) end of the if_ram protocol: accepts NOP/FETCH/STORE requests of BYTE/WORD/LONG/QUAD size from one client (loader, debugger, later the CPU).
- Backed by a byte-wide synchronous block RAM.
- Multi-byte accesses are serialised one byte per cycle, big-endian (byte at addr is most significant).
- Sits between the if_ram client and the on-chip EBR.

Parameters:
- DEPTH, 8192, bytes of storage; power of two; address used modulo DEPTH.
- INIT_FILE, "", hex file loaded into the byte array at configuration; empty means all zero.

Ports:
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- ram  if_ram.server  -  op, data_type, addr[RAM_ADDRW], data_in[RAM_QUAD_SIZE] in; data_out[RAM_QUAD_SIZE] out
- busy  out  1  high while a request is in progress; requests are ignored while high
- err  out  1  sticky misalignment flag (only with RAM_ALIGN_CHECK_EN; tied 0 otherwise)

Behaviour:
- Reset (async assert, sync release): state IDLE, busy=0, data_out=0, err=0, byte counter=0, accumulator=0. Memory contents are not cleared.
- N = size in bytes: BYTE=1, WORD=2, LONG=4, QUAD=8.
- Base = addr with its low log2(N) bits cleared. Byte i is at base+i, i=0..N-1. No wrap across the aligned block; above DEPTH wraps modulo DEPTH.
- IDLE:
  - op is sampled every cycle.
  - NOP: stay in IDLE.
  - FETCH: latch base/N, busy<=1, go to RD.
  - STORE: latch base/N/data_in, busy<=1, go to WR.
- RD:
  - Issue a read of base+i on cycles i=0..N-1.
  - Synchronous RAM returns each byte one cycle later; shift into the accumulator (acc <= {acc[55:0], byte}).
  - One cycle after the last byte returns: data_out <= zero-extended acc (low 8*N bits valid, upper bits 0), busy<=0, go to IDLE.
  - FETCH latency from request edge to busy low and data_out valid: N+1 cycles.
- WR:
  - On cycle i, write byte data_in[8*(N-1-i)+7 -: 8] to base+i.
  - After the write of i=N-1: busy<=0, go to IDLE. Latency N cycles.
  - data_out is unchanged by STORE.
- data_out holds its last FETCH value until the next FETCH completes.
- Request while busy: ignored entirely, not queued; clients must see busy=0 before issuing.
- Client holding op=FETCH for several cycles: each cycle with busy=0 in IDLE starts a new access. Clients pulse op for one cycle.
- Reset mid-operation: access aborted immediately. Bytes already written by a partial STORE stay written; data_out returns to 0.
- Unknown op encoding: treated as NOP.

Optional Feature:
- Macro: RAM_ALIGN_CHECK_EN.
- Defined:
  - A FETCH or STORE with nonzero addr[log2(N)-1:0] performs no memory access.
  - data_out is unchanged, busy stays 0, err is set to 1.
  - err is cleared only by rst_n.
- Undefined:
  - Low address bits are silently masked to form base.
  - err is tied to 0 and the check logic is absent.

Decomposition:
- pkg_ram gets:
  - RAM_STORE op, if not already present.
  - Function ram_size_bytes(data_type) returning N.
  - Function ram_align_mask(data_type).
  - Constant RAM_MAX_BYTES=8.
- State enum (IDLE, RD, WR) is local to the module.
- Sub-module ram_byte_bank: single-port synchronous byte RAM (DEPTH, INIT_FILE; we, addr, din, dout with 1-cycle read latency). It keeps EBR inference isolated and reusable.

Test Plan:
- STORE QUAD addr=0x10, data_in=0x0123456789ABCDEF, then FETCH BYTE 0x10..0x17:
  - Byte reads return 01,23,45,67,89,AB,CD,EF.
  - STORE busy lasts 8 cycles; each byte FETCH has busy high for 2 cycles.
- FETCH LONG 0x14 after the above -> data_out=0x0000000089ABCDEF exactly 5 cycles after request.
- STORE WORD addr=0x21 (masked to 0x20), data_in=0xFFFFFFFFFFFFBEEF:
  - Without RAM_ALIGN_CHECK_EN: bytes 0x20=BE, 0x21=EF.
  - With RAM_ALIGN_CHECK_EN: memory unchanged, err=1, busy never rises.
- Issue FETCH QUAD, then pulse STORE BYTE while busy -> STORE is ignored, memory byte unchanged, FETCH result correct.
- Start STORE QUAD 0x40 data 0x1122334455667788, assert rst_n=0 after 3 busy cycles:
  - busy=0 and data_out=0 immediately.
  - Afterwards 0x40..0x42 = 11,22,33 and 0x43..0x47 hold their old values.
- FETCH BYTE at addr=DEPTH+5 -> returns the byte stored at address 5.

Source files
------------

// File: rtl/dev_ram_responder_pkg.sv
// Shared types and helpers for the if_ram protocol: op/size encodings and byte-size math.
package dev_ram_responder_pkg;

  localparam int RAM_ADDRW     = 16;
  localparam int RAM_QUAD_SIZE = 64;
  localparam int RAM_MAX_BYTES = 8;

  // Encoding 2'd3 is unassigned and behaves as NOP at the responder.
  typedef enum logic [1:0] {
    RAM_NOP   = 2'd0,
    RAM_FETCH = 2'd1,
    RAM_STORE = 2'd2
  } ram_op_t;

  typedef enum logic [1:0] {
    RAM_BYTE = 2'd0,
    RAM_WORD = 2'd1,
    RAM_LONG = 2'd2,
    RAM_QUAD = 2'd3
  } ram_dtype_t;

  function automatic logic [3:0] ram_size_bytes(input ram_dtype_t dt);
    case (dt)
      RAM_BYTE: return 4'd1;
      RAM_WORD: return 4'd2;
      RAM_LONG: return 4'd4;
      default:  return 4'd8;
    endcase
  endfunction

  function automatic logic [RAM_ADDRW-1:0] ram_align_mask(input ram_dtype_t dt);
    return RAM_ADDRW'(ram_size_bytes(dt) - 4'd1);
  endfunction

endpackage

// File: rtl/dev_ram_responder_if.sv
// if_ram request/response bundle; server modport faces the responder, client modport the requester.
interface dev_ram_responder_if;
  import dev_ram_responder_pkg::*;

  ram_op_t                  op;
  ram_dtype_t               data_type;
  logic [RAM_ADDRW-1:0]     addr;
  logic [RAM_QUAD_SIZE-1:0] data_in;
  logic [RAM_QUAD_SIZE-1:0] data_out;

  modport server (input op, data_type, addr, data_in, output data_out);
  modport client (output op, data_type, addr, data_in, input data_out);

endinterface

// File: rtl/dev_ram_responder_byte_bank.sv
// ram_byte_bank: single-port byte-wide synchronous RAM, one-cycle read latency.
module ram_byte_bank #(
  parameter int    DEPTH     = 8192,
  parameter string INIT_FILE = ""
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [7:0]               din,
  output logic [7:0]               dout
);

  logic [7:0] mem [DEPTH];

  // Read-before-write; the responder never reads and writes the same cycle anyway.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= din;
    end
    dout <= mem[addr];
  end

endmodule

// File: rtl/dev_ram_responder.sv
// if_ram responder over a byte RAM: serialises BYTE..QUAD accesses big-endian, one byte per cycle.
// Optional macro RAM_ALIGN_CHECK_EN rejects misaligned requests and raises a sticky err.
module dev_ram_responder
  import dev_ram_responder_pkg::*;
#(
  parameter int    DEPTH     = 8192,
  parameter string INIT_FILE = ""
) (
  input  logic                  clk,
  input  logic                  rst_n,
  dev_ram_responder_if.server   ram,
  output logic                  busy,
  output logic                  err
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, RD, WR} state_t;

  state_t                   state_reg;
  logic [AW-1:0]            base_reg;
  logic [3:0]               n_reg;
  logic [3:0]               idx_reg;
  logic [63:0]              acc_reg;
  logic [63:0]              wdata_reg;
  logic [63:0]              data_out_reg;
  logic                     busy_reg;

  logic [RAM_ADDRW-1:0]     req_base;
  logic [3:0]               req_n;
  logic                     misaligned;
  logic                     unused_addr_bits;

  logic                     bank_we;
  logic [AW-1:0]            bank_addr;
  logic [7:0]               bank_din;
  logic [7:0]               bank_dout;
  logic [63:0]              acc_shift;

  assign req_n            = ram_size_bytes(ram.data_type);
  assign req_base         = ram.addr & ~ram_align_mask(ram.data_type);
  assign unused_addr_bits = ^req_base[RAM_ADDRW-1:AW];

`ifdef RAM_ALIGN_CHECK_EN
  logic err_reg;
  assign misaligned = |(ram.addr & ram_align_mask(ram.data_type));
  assign err        = err_reg;
`else
  assign misaligned = 1'b0;
  assign err        = 1'b0;
`endif

  // Blocks are aligned, so OR-ing the byte index never carries out of the block.
  assign bank_we   = (state_reg == WR);
  assign bank_addr = base_reg | AW'(idx_reg[2:0]);
  assign bank_din  = wdata_reg[63:56];
  assign acc_shift = {acc_reg[55:0], bank_dout};

  assign busy         = busy_reg;
  assign ram.data_out = data_out_reg;

  ram_byte_bank #(
    .DEPTH     (DEPTH),
    .INIT_FILE (INIT_FILE)
  ) u_bank (
    .clk  (clk),
    .we   (bank_we),
    .addr (bank_addr),
    .din  (bank_din),
    .dout (bank_dout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      base_reg     <= '0;
      n_reg        <= '0;
      idx_reg      <= '0;
      acc_reg      <= '0;
      wdata_reg    <= '0;
      data_out_reg <= '0;
      busy_reg     <= 1'b0;
`ifdef RAM_ALIGN_CHECK_EN
      err_reg      <= 1'b0;
`endif
    end else begin
      case (state_reg)
        IDLE: begin
          if ((ram.op == RAM_FETCH || ram.op == RAM_STORE) && !misaligned) begin
            base_reg  <= req_base[AW-1:0];
            n_reg     <= req_n;
            idx_reg   <= '0;
            acc_reg   <= '0;
            // Left-justify the N valid bytes so the next byte to write is always [63:56].
            wdata_reg <= ram.data_in << (7'd64 - {req_n, 3'b000});
            busy_reg  <= 1'b1;
            state_reg <= (ram.op == RAM_FETCH) ? RD : WR;
          end
`ifdef RAM_ALIGN_CHECK_EN
          if ((ram.op == RAM_FETCH || ram.op == RAM_STORE) && misaligned) begin
            err_reg <= 1'b1;
          end
`endif
        end

        // idx counts issued reads; the byte for read idx-1 is on bank_dout now.
        RD: begin
          if (idx_reg != 4'd0) begin
            acc_reg <= acc_shift;
          end
          if (idx_reg == n_reg) begin
            data_out_reg <= acc_shift;
            busy_reg     <= 1'b0;
            state_reg    <= IDLE;
          end else begin
            idx_reg <= idx_reg + 4'd1;
          end
        end

        WR: begin
          wdata_reg <= wdata_reg << 8;
          if (idx_reg == n_reg - 4'd1) begin
            idx_reg   <= '0;
            busy_reg  <= 1'b0;
            state_reg <= IDLE;
          end else begin
            idx_reg <= idx_reg + 4'd1;
          end
        end

        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dev_ram_responder.sv
// Directed, table-driven bench for dev_ram_responder plus hand-written multi-cycle corner cases.
module tb_dev_ram_responder;
  import dev_ram_responder_pkg::*;

  localparam int NVEC = 18;

  typedef struct {
    ram_op_t    op;
    ram_dtype_t dt;
    logic [15:0] addr;
    logic [63:0] din;
    int          lat;
    logic [63:0] dout;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic busy;
  logic err;
  int   n_total = 0;
  int   n_pass  = 0;
  vec_t vecs [NVEC];

  dev_ram_responder_if ram_if ();

  dev_ram_responder dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ram   (ram_if),
    .busy  (busy),
    .err   (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) begin
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end else begin
      n_pass++;
    end
  endtask

  // Drive one request for a single edge, then count edges until busy drops.
  task automatic run_req(input ram_op_t op, input ram_dtype_t dt, input logic [15:0] a,
                         input logic [63:0] d, output int lat);
    @(negedge clk);
    ram_if.op        = op;
    ram_if.data_type = dt;
    ram_if.addr      = a;
    ram_if.data_in   = d;
    @(posedge clk);
    #1;
    ram_if.op = RAM_NOP;
    lat = 0;
    while (busy && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  initial begin
    int lat;
    int waited;

    vecs[0]  = '{RAM_STORE, RAM_QUAD, 16'h0010, 64'h0123456789ABCDEF, 8, 64'h0};
    vecs[1]  = '{RAM_FETCH, RAM_BYTE, 16'h0010, 64'h0, 2, 64'h01};
    vecs[2]  = '{RAM_FETCH, RAM_BYTE, 16'h0011, 64'h0, 2, 64'h23};
    vecs[3]  = '{RAM_FETCH, RAM_BYTE, 16'h0012, 64'h0, 2, 64'h45};
    vecs[4]  = '{RAM_FETCH, RAM_BYTE, 16'h0013, 64'h0, 2, 64'h67};
    vecs[5]  = '{RAM_FETCH, RAM_BYTE, 16'h0014, 64'h0, 2, 64'h89};
    vecs[6]  = '{RAM_FETCH, RAM_BYTE, 16'h0015, 64'h0, 2, 64'hAB};
    vecs[7]  = '{RAM_FETCH, RAM_BYTE, 16'h0016, 64'h0, 2, 64'hCD};
    vecs[8]  = '{RAM_FETCH, RAM_BYTE, 16'h0017, 64'h0, 2, 64'hEF};
    vecs[9]  = '{RAM_FETCH, RAM_LONG, 16'h0014, 64'h0, 5, 64'h0000000089ABCDEF};
    vecs[10] = '{RAM_FETCH, RAM_WORD, 16'h0016, 64'h0, 3, 64'h000000000000CDEF};
    vecs[11] = '{RAM_FETCH, RAM_QUAD, 16'h0010, 64'h0, 9, 64'h0123456789ABCDEF};
    vecs[12] = '{RAM_STORE, RAM_BYTE, 16'h0005, 64'hFFFFFFFFFFFFFF5A, 1, 64'h0123456789ABCDEF};
    vecs[13] = '{RAM_FETCH, RAM_BYTE, 16'd8197, 64'h0, 2, 64'h5A};
    vecs[14] = '{ram_op_t'(2'd3), RAM_QUAD, 16'h0010, 64'h0, 0, 64'h5A};
    vecs[15] = '{RAM_STORE, RAM_LONG, 16'h0040, 64'h00000000A0B0C0D0, 4, 64'h5A};
    vecs[16] = '{RAM_STORE, RAM_LONG, 16'h0044, 64'h00000000E0F01020, 4, 64'h5A};
    vecs[17] = '{RAM_FETCH, RAM_QUAD, 16'h0040, 64'h0, 9, 64'hA0B0C0D0E0F01020};

    ram_if.op        = RAM_NOP;
    ram_if.data_type = RAM_BYTE;
    ram_if.addr      = '0;
    ram_if.data_in   = '0;

    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", 64'(busy), 64'h0);
    check("reset_data_out", ram_if.data_out, 64'h0);
    check("reset_err", 64'(err), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < NVEC; i++) begin
      run_req(vecs[i].op, vecs[i].dt, vecs[i].addr, vecs[i].din, lat);
      $display("vec %0d op=%0d dt=%0d addr=%h lat=%0d data_out=%h",
               i, vecs[i].op, vecs[i].dt, vecs[i].addr, lat, ram_if.data_out);
      check($sformatf("vec%0d_latency", i), 64'(lat), 64'(vecs[i].lat));
      check($sformatf("vec%0d_data_out", i), ram_if.data_out, vecs[i].dout);
    end

    // Misaligned STORE WORD at 0x21 over a known 0x20/0x21 pair.
    run_req(RAM_STORE, RAM_WORD, 16'h0020, 64'h0000000000001234, lat);
    run_req(RAM_STORE, RAM_WORD, 16'h0021, 64'hFFFFFFFFFFFFBEEF, lat);
    $display("seq misaligned store lat=%0d err=%0d", lat, err);
`ifdef RAM_ALIGN_CHECK_EN
    check("misalign_store_latency", 64'(lat), 64'd0);
    check("misalign_err", 64'(err), 64'h1);
    run_req(RAM_FETCH, RAM_WORD, 16'h0020, 64'h0, lat);
    check("misalign_readback", ram_if.data_out, 64'h1234);
`else
    check("misalign_store_latency", 64'(lat), 64'd2);
    check("misalign_err", 64'(err), 64'h0);
    run_req(RAM_FETCH, RAM_WORD, 16'h0020, 64'h0, lat);
    check("misalign_readback", ram_if.data_out, 64'hBEEF);
`endif

    // STORE pulsed while a FETCH QUAD is in flight must be dropped.
    @(negedge clk);
    ram_if.op = RAM_FETCH; ram_if.data_type = RAM_QUAD; ram_if.addr = 16'h0010;
    @(negedge clk);
    ram_if.op = RAM_NOP;
    @(negedge clk);
    check("busy_during_fetch", 64'(busy), 64'h1);
    ram_if.op = RAM_STORE; ram_if.data_type = RAM_BYTE; ram_if.addr = 16'h0012;
    ram_if.data_in = 64'h77;
    @(negedge clk);
    ram_if.op = RAM_NOP;
    waited = 0;
    while (busy && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    check("fetch_wait_bounded", 64'(waited < 50), 64'h1);
    check("fetch_during_ignore", ram_if.data_out, 64'h0123456789ABCDEF);
    run_req(RAM_FETCH, RAM_BYTE, 16'h0012, 64'h0, lat);
    $display("seq ignored store readback=%h", ram_if.data_out);
    check("ignored_store_byte", ram_if.data_out, 64'h45);

    // Reset three busy cycles into a STORE QUAD: first three bytes land, rest keep old data.
    @(negedge clk);
    ram_if.op = RAM_STORE; ram_if.data_type = RAM_QUAD; ram_if.addr = 16'h0040;
    ram_if.data_in = 64'h1122334455667788;
    @(posedge clk);
    #1;
    ram_if.op = RAM_NOP;
    repeat (3) @(posedge clk);
    #1;
    check("busy_before_reset", 64'(busy), 64'h1);
    rst_n = 1'b0;
    #1;
    check("abort_busy", 64'(busy), 64'h0);
    check("abort_data_out", ram_if.data_out, 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    run_req(RAM_FETCH, RAM_QUAD, 16'h0040, 64'h0, lat);
    $display("seq aborted store readback=%h lat=%0d", ram_if.data_out, lat);
    check("abort_partial_store", ram_if.data_out, 64'h112233D0E0F01020);
    check("abort_fetch_latency", 64'(lat), 64'd9);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
